// File: rtl/mips_mc_control_pkg.sv
// Shared constants and enums for the multicycle MIPS control unit:
// opcode/funct codes, ALU operation codes, FSM states and instruction classes.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // funct codes under OP_RTYPE; addm is a non-standard reg+mem add
  localparam logic [5:0] OP0_JR   = 6'h08;
  localparam logic [5:0] OP0_ADD  = 6'h20;
  localparam logic [5:0] OP0_SUB  = 6'h22;
  localparam logic [5:0] OP0_AND  = 6'h24;
  localparam logic [5:0] OP0_OR   = 6'h25;
  localparam logic [5:0] OP0_XOR  = 6'h26;
  localparam logic [5:0] OP0_NOR  = 6'h27;
  localparam logic [5:0] OP0_SLT  = 6'h2a;
  localparam logic [5:0] OP0_ADDM = 6'h2c;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_EXCEPT
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_IMM, CLS_LUI, CLS_SLT, CLS_BRANCH, CLS_JUMP,
    CLS_JR, CLS_LOAD, CLS_STORE, CLS_ADDM, CLS_BAD
  } cls_e;

endpackage

// File: rtl/mips_mc_control_if.sv
// Ready-handshaked instruction and data memory request ports.
interface mips_mc_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
  modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);
endinterface

// File: rtl/mips_mc_control_class_decode.sv
// Combinational instruction classifier: opcode/funct to class and the static
// datapath selects that stay constant for the whole instruction.
module mips_class_decode
  import mips_mc_pkg::*;
#(
  parameter bit ENABLE_ADDM = 1'b1,
  parameter bit ENABLE_BYTE = 1'b1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [2:0] alu_op_o,
  output logic       rd_src_o,
  output logic       alu_src2_o
);

  always_comb begin
    cls_o      = CLS_BAD;
    alu_op_o   = ALU_NONE;
    rd_src_o   = 1'b0;
    alu_src2_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          OP0_ADD: begin cls_o = CLS_ALU; alu_op_o = ALU_ADD; end
          OP0_SUB: begin cls_o = CLS_ALU; alu_op_o = ALU_SUB; end
          OP0_AND: begin cls_o = CLS_ALU; alu_op_o = ALU_AND; end
          OP0_OR:  begin cls_o = CLS_ALU; alu_op_o = ALU_OR;  end
          OP0_NOR: begin cls_o = CLS_ALU; alu_op_o = ALU_NOR; end
          OP0_XOR: begin cls_o = CLS_ALU; alu_op_o = ALU_XOR; end
          OP0_SLT: begin cls_o = CLS_SLT; alu_op_o = ALU_SUB; end
          OP0_JR:  cls_o = CLS_JR;
          OP0_ADDM: begin
            if (ENABLE_ADDM) begin
              cls_o    = CLS_ADDM;
              alu_op_o = ALU_ADD;
            end
          end
          default: ;
        endcase
      end
      // I-type results land in rt and take the immediate as operand 2
      OP_ADDI: begin cls_o = CLS_IMM; alu_op_o = ALU_ADD; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_ANDI: begin cls_o = CLS_IMM; alu_op_o = ALU_AND; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_ORI:  begin cls_o = CLS_IMM; alu_op_o = ALU_OR;  rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_XORI: begin cls_o = CLS_IMM; alu_op_o = ALU_XOR; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_SLTI: begin cls_o = CLS_SLT; alu_op_o = ALU_SUB; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_LUI:  begin cls_o = CLS_LUI; alu_op_o = ALU_ADD; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_BEQ, OP_BNE: begin cls_o = CLS_BRANCH; alu_op_o = ALU_SUB; end
      OP_J:    cls_o = CLS_JUMP;
      OP_LW:   begin cls_o = CLS_LOAD; alu_op_o = ALU_ADD; rd_src_o = 1'b1; alu_src2_o = 1'b1; end
      OP_SW:   begin cls_o = CLS_STORE; alu_op_o = ALU_ADD; alu_src2_o = 1'b1; end
      OP_LBU: begin
        if (ENABLE_BYTE) begin
          cls_o = CLS_LOAD; alu_op_o = ALU_ADD; rd_src_o = 1'b1; alu_src2_o = 1'b1;
        end
      end
      OP_SB: begin
        if (ENABLE_BYTE) begin
          cls_o = CLS_STORE; alu_op_o = ALU_ADD; alu_src2_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: fetch/decode/mem/writeback sequencing, memory
// wait timeout into a sticky exception, and per-state datapath strobe gating.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter bit          ENABLE_ADDM = 1'b1,
  parameter bit          ENABLE_BYTE = 1'b1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mips_mc_control_if.master mem,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic              zero_i,
  output logic              ir_we_o,
  output logic [2:0]        alu_op_o,
  output logic              rd_src_o,
  output logic              alu_src2_o,
  output logic              reg_we_o,
  output logic              pc_we_o,
  output logic [1:0]        control_type_o,
  output logic              mem_read_o,
  output logic              word_we_o,
  output logic              byte_we_o,
  output logic              byte_load_o,
  output logic              lui_o,
  output logic              slt_o,
  output logic              addm_o,
  output logic              except_o,
  output logic              busy_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e     state_q;
  logic [7:0] cnt_q;
  cls_e       cls;
  logic [2:0] s_alu_op;
  logic       s_rd_src, s_alu_src2;
  logic       at_limit, is_byte, br_taken, is_memrd;

  mips_class_decode #(
    .ENABLE_ADDM(ENABLE_ADDM),
    .ENABLE_BYTE(ENABLE_BYTE)
  ) u_dec (
    .opcode_i  (opcode_i),
    .funct_i   (funct_i),
    .cls_o     (cls),
    .alu_op_o  (s_alu_op),
    .rd_src_o  (s_rd_src),
    .alu_src2_o(s_alu_src2)
  );

  assign at_limit = (cnt_q == TMO);
  assign is_byte  = (opcode_i == OP_LBU) || (opcode_i == OP_SB);
  assign br_taken = (opcode_i == OP_BEQ) ? zero_i : !zero_i;
  assign is_memrd = (cls == CLS_LOAD) || (cls == CLS_ADDM);

  // A ready arriving on the limit cycle is checked first, so it wins over timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        S_FETCH: begin
          if (mem.imem_ready)  state_q <= S_DECODE;
          else if (at_limit)   state_q <= S_EXCEPT;
          else                 cnt_q   <= cnt_q + 8'd1;
        end
        S_DECODE: begin
          cnt_q <= '0;
          case (cls)
            CLS_BAD:                      state_q <= S_EXCEPT;
            CLS_LOAD, CLS_STORE, CLS_ADDM: state_q <= S_MEM;
            default:                      state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem.dmem_ready) begin
            state_q <= (cls == CLS_STORE) ? S_FETCH : S_WB;
            cnt_q   <= '0;
          end else if (at_limit) begin
            state_q <= S_EXCEPT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        default: state_q <= S_EXCEPT;
      endcase
    end
  end

  always_comb begin
    mem.imem_req   = 1'b0;
    mem.dmem_req   = 1'b0;
    ir_we_o        = 1'b0;
    alu_op_o       = ALU_NONE;
    rd_src_o       = 1'b0;
    alu_src2_o     = 1'b0;
    reg_we_o       = 1'b0;
    pc_we_o        = 1'b0;
    control_type_o = 2'b00;
    mem_read_o     = 1'b0;
    word_we_o      = 1'b0;
    byte_we_o      = 1'b0;
    byte_load_o    = 1'b0;
    lui_o          = 1'b0;
    slt_o          = 1'b0;
    addm_o         = 1'b0;
    except_o       = 1'b0;
    busy_o         = (state_q != S_IDLE) && (state_q != S_EXCEPT);
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_we_o      = mem.imem_ready;
      end
      S_DECODE: begin
        alu_op_o   = s_alu_op;
        rd_src_o   = s_rd_src;
        alu_src2_o = s_alu_src2;
        case (cls)
          CLS_ALU, CLS_IMM: begin reg_we_o = 1'b1; pc_we_o = 1'b1; end
          CLS_LUI: begin lui_o = 1'b1; reg_we_o = 1'b1; pc_we_o = 1'b1; end
          CLS_SLT: begin slt_o = 1'b1; reg_we_o = 1'b1; pc_we_o = 1'b1; end
          CLS_BRANCH: begin
            pc_we_o        = 1'b1;
            control_type_o = br_taken ? 2'b01 : 2'b00;
          end
          CLS_JUMP: begin pc_we_o = 1'b1; control_type_o = 2'b10; end
          CLS_JR:   begin pc_we_o = 1'b1; control_type_o = 2'b11; end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        alu_op_o     = s_alu_op;
        rd_src_o     = s_rd_src;
        alu_src2_o   = s_alu_src2;
        mem_read_o   = is_memrd;
        byte_load_o  = is_memrd && is_byte;
        if (mem.dmem_ready && (cls == CLS_STORE)) begin
          word_we_o = !is_byte;
          byte_we_o = is_byte;
          pc_we_o   = 1'b1;
        end
      end
      S_WB: begin
        alu_op_o   = (cls == CLS_ADDM) ? ALU_ADD : s_alu_op;
        rd_src_o   = s_rd_src;
        alu_src2_o = s_alu_src2;
        reg_we_o   = 1'b1;
        pc_we_o    = 1'b1;
        mem_read_o = 1'b1;
        addm_o     = (cls == CLS_ADDM);
      end
      S_EXCEPT: except_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed per-cycle vectors for the multicycle control unit; expected output
// words go into a queue and a negedge monitor compares them against the DUTs.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, iready = 1'b0, dready = 1'b0;

  always #5 clk = ~clk;

  // Output word: {imem_req, ir_we, dmem_req, alu_op[2:0], rd_src, alu_src2,
  //   reg_we, pc_we, control_type[1:0], mem_read, word_we, byte_we,
  //   byte_load, lui, slt, addm, except, busy}
  wire [20:0] outa, outb;

  mips_mc_control_if mif_a ();
  mips_mc_control_if mif_b ();
  assign mif_a.imem_ready = iready;
  assign mif_a.dmem_ready = dready;
  assign mif_b.imem_ready = iready;
  assign mif_b.dmem_ready = dready;
  assign outa[20] = mif_a.imem_req;
  assign outa[18] = mif_a.dmem_req;
  assign outb[20] = mif_b.imem_req;
  assign outb[18] = mif_b.dmem_req;

  mips_mc_control #(.ENABLE_ADDM(1'b1), .ENABLE_BYTE(1'b1), .TIMEOUT(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mem(mif_a),
    .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .ir_we_o(outa[19]), .alu_op_o(outa[17:15]), .rd_src_o(outa[14]),
    .alu_src2_o(outa[13]), .reg_we_o(outa[12]), .pc_we_o(outa[11]),
    .control_type_o(outa[10:9]), .mem_read_o(outa[8]), .word_we_o(outa[7]),
    .byte_we_o(outa[6]), .byte_load_o(outa[5]), .lui_o(outa[4]),
    .slt_o(outa[3]), .addm_o(outa[2]), .except_o(outa[1]), .busy_o(outa[0])
  );

  mips_mc_control #(.ENABLE_ADDM(1'b0), .ENABLE_BYTE(1'b1), .TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mem(mif_b),
    .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .ir_we_o(outb[19]), .alu_op_o(outb[17:15]), .rd_src_o(outb[14]),
    .alu_src2_o(outb[13]), .reg_we_o(outb[12]), .pc_we_o(outb[11]),
    .control_type_o(outb[10:9]), .mem_read_o(outb[8]), .word_we_o(outb[7]),
    .byte_we_o(outb[6]), .byte_load_o(outb[5]), .lui_o(outb[4]),
    .slt_o(outb[3]), .addm_o(outb[2]), .except_o(outb[1]), .busy_o(outb[0])
  );

  localparam logic [20:0] BSY   = 21'h000001;
  localparam logic [20:0] EXC   = 21'h000002;
  localparam logic [20:0] ADM   = 21'h000004;
  localparam logic [20:0] SLT   = 21'h000008;
  localparam logic [20:0] LUI   = 21'h000010;
  localparam logic [20:0] BLD   = 21'h000020;
  localparam logic [20:0] BWE   = 21'h000040;
  localparam logic [20:0] WWE   = 21'h000080;
  localparam logic [20:0] MRD   = 21'h000100;
  localparam logic [20:0] PCWE  = 21'h000800;
  localparam logic [20:0] REGWE = 21'h001000;
  localparam logic [20:0] AS2   = 21'h002000;
  localparam logic [20:0] RDS   = 21'h004000;
  localparam logic [20:0] DMREQ = 21'h040000;
  localparam logic [20:0] IRWE  = 21'h080000;
  localparam logic [20:0] IMREQ = 21'h100000;
  localparam logic [20:0] FET   = IMREQ | IRWE | BSY;

  function automatic logic [20:0] alu(input logic [2:0] op);
    return 21'(op) << 15;
  endfunction

  function automatic logic [20:0] ctl(input logic [1:0] t);
    return 21'(t) << 9;
  endfunction

  logic [42:0] expq[$];
  int          idq[$];
  int          vid = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic ir, input logic dr,
                      input logic [20:0] ea, input logic cb = 1'b0,
                      input logic [20:0] eb = 21'h0);
    @(posedge clk);
    #1;
    rst_n  = r;
    opcode = op;
    funct  = fn;
    zero   = z;
    iready = ir;
    dready = dr;
    expq.push_back({cb, eb, ea});
    idq.push_back(vid);
    vid++;
  endtask

  initial begin : monitor
    logic [42:0] e;
    int          id;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        id = idq.pop_front();
        checks++;
        if (outa !== e[20:0]) begin
          failures++;
          $display("FAIL out_a vec=%0d got=%h expected=%h", id, outa, e[20:0]);
        end
        if (e[42]) begin
          checks++;
          if (outb !== e[41:21]) begin
            failures++;
            $display("FAIL out_b vec=%0d got=%h expected=%h", id, outb, e[41:21]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset, ready inputs ignored while held
    step(0, 6'h00, 6'h00, 0, 0, 0, 21'h0);
    step(0, 6'h00, 6'h00, 0, 1, 1, 21'h0);
    step(1, 6'h00, 6'h20, 0, 1, 0, 21'h0);
    // add
    step(1, 6'h00, 6'h20, 0, 1, 0, FET);
    step(1, 6'h00, 6'h20, 0, 0, 0, alu(3'b010) | REGWE | PCWE | BSY);
    step(1, 6'h00, 6'h20, 0, 0, 0, IMREQ | BSY);
    // lw, three wait cycles
    step(1, 6'h23, 6'h00, 0, 1, 0, FET);
    step(1, 6'h23, 6'h00, 0, 0, 1, alu(3'b010) | RDS | AS2 | BSY);
    for (int i = 0; i < 3; i++)
      step(1, 6'h23, 6'h00, 0, 0, 0, DMREQ | MRD | alu(3'b010) | RDS | AS2 | BSY);
    step(1, 6'h23, 6'h00, 0, 0, 1, DMREQ | MRD | alu(3'b010) | RDS | AS2 | BSY);
    step(1, 6'h23, 6'h00, 0, 0, 0, REGWE | PCWE | MRD | alu(3'b010) | RDS | AS2 | BSY);
    // beq taken / not taken, bne taken, j, jr
    step(1, 6'h04, 6'h00, 1, 1, 0, FET);
    step(1, 6'h04, 6'h00, 1, 0, 0, alu(3'b011) | PCWE | ctl(2'b01) | BSY);
    step(1, 6'h04, 6'h00, 0, 1, 0, FET);
    step(1, 6'h04, 6'h00, 0, 0, 0, alu(3'b011) | PCWE | BSY);
    step(1, 6'h05, 6'h00, 0, 1, 0, FET);
    step(1, 6'h05, 6'h00, 0, 0, 0, alu(3'b011) | PCWE | ctl(2'b01) | BSY);
    step(1, 6'h02, 6'h00, 0, 1, 0, FET);
    step(1, 6'h02, 6'h00, 0, 0, 0, PCWE | ctl(2'b10) | BSY);
    step(1, 6'h00, 6'h08, 0, 1, 0, FET);
    step(1, 6'h00, 6'h08, 0, 0, 0, PCWE | ctl(2'b11) | BSY);
    // addm: enabled in dut_a, unknown in dut_b
    step(1, 6'h00, 6'h2c, 0, 1, 0, FET, 1, FET);
    step(1, 6'h00, 6'h2c, 0, 0, 0, alu(3'b010) | BSY, 1, BSY);
    step(1, 6'h00, 6'h2c, 0, 0, 1, DMREQ | MRD | alu(3'b010) | BSY, 1, EXC);
    step(1, 6'h00, 6'h2c, 0, 0, 0, REGWE | PCWE | MRD | ADM | alu(3'b010) | BSY, 1, EXC);
    // lui
    step(1, 6'h0f, 6'h00, 0, 1, 0, FET);
    step(1, 6'h0f, 6'h00, 0, 0, 0, alu(3'b010) | RDS | AS2 | LUI | REGWE | PCWE | BSY);
    // sw, ready arrives on the limit cycle
    step(1, 6'h2b, 6'h00, 0, 1, 0, FET);
    step(1, 6'h2b, 6'h00, 0, 0, 0, alu(3'b010) | AS2 | BSY);
    for (int i = 0; i < 4; i++)
      step(1, 6'h2b, 6'h00, 0, 0, 0, DMREQ | alu(3'b010) | AS2 | BSY);
    step(1, 6'h2b, 6'h00, 0, 0, 1, DMREQ | alu(3'b010) | AS2 | WWE | PCWE | BSY);
    // sw, ready never arrives
    step(1, 6'h2b, 6'h00, 0, 1, 0, FET);
    step(1, 6'h2b, 6'h00, 0, 0, 0, alu(3'b010) | AS2 | BSY);
    for (int i = 0; i < 5; i++)
      step(1, 6'h2b, 6'h00, 0, 0, 0, DMREQ | alu(3'b010) | AS2 | BSY);
    step(1, 6'h2b, 6'h00, 0, 0, 0, EXC, 1, EXC);
    step(1, 6'h2b, 6'h00, 0, 1, 1, EXC);
    // reset out of EXCEPT, then reset in the middle of sb
    step(0, 6'h28, 6'h00, 0, 0, 0, 21'h0, 1, 21'h0);
    step(1, 6'h28, 6'h00, 0, 1, 0, 21'h0);
    step(1, 6'h28, 6'h00, 0, 1, 0, FET);
    step(1, 6'h28, 6'h00, 0, 0, 0, alu(3'b010) | AS2 | BSY);
    step(1, 6'h28, 6'h00, 0, 0, 0, DMREQ | alu(3'b010) | AS2 | BSY);
    step(0, 6'h28, 6'h00, 0, 0, 1, 21'h0);
    step(1, 6'h28, 6'h00, 0, 0, 1, 21'h0);
    step(1, 6'h28, 6'h00, 0, 0, 0, IMREQ | BSY, 1, IMREQ | BSY);
    // lbu
    step(1, 6'h24, 6'h00, 0, 1, 0, FET);
    step(1, 6'h24, 6'h00, 0, 0, 0, alu(3'b010) | RDS | AS2 | BSY);
    step(1, 6'h24, 6'h00, 0, 0, 1, DMREQ | MRD | BLD | alu(3'b010) | RDS | AS2 | BSY);
    step(1, 6'h24, 6'h00, 0, 0, 0, REGWE | PCWE | MRD | alu(3'b010) | RDS | AS2 | BSY);
    // slt
    step(1, 6'h00, 6'h2a, 0, 1, 0, FET);
    step(1, 6'h00, 6'h2a, 0, 0, 0, alu(3'b011) | SLT | REGWE | PCWE | BSY);
    // sb completing
    step(1, 6'h28, 6'h00, 0, 1, 0, FET);
    step(1, 6'h28, 6'h00, 0, 0, 0, alu(3'b010) | AS2 | BSY);
    step(1, 6'h28, 6'h00, 0, 0, 1, DMREQ | alu(3'b010) | AS2 | BWE | PCWE | BSY);
    step(1, 6'h00, 6'h20, 0, 0, 0, IMREQ | BSY);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
